// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter: pipeline writeback vs buffered long-latency results
// Also tracks which registers are still waiting on a long-latency result, and stalls decode on them.
module regfile_wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_addr,
   input  logic [31:0] pipe_data,
   input  logic        lu_valid,
   input  logic [4:0]  lu_addr,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_addr,
   input  logic [4:0]  rs_addr1,
   input  logic [4:0]  rs_addr2,
   output logic        stall,
   output logic        force_stall,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        waw_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    fifo_addr [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   pending;
   logic [SW-1:0] starve_cnt;

   logic        pipe_req;
   logic        fifo_empty;
   logic        enq;
   logic        drain;
   logic [4:0]  head_addr;
   logic [31:0] head_data;

   assign pipe_req   = pipe_we && (pipe_addr != 5'd0);
   assign fifo_empty = (count == '0);
   assign lu_ready   = (count < CW'(DEPTH));
   // Results for r0 are acknowledged but dropped, so they never reach the write port.
   assign enq        = lu_valid && lu_ready && (lu_addr != 5'd0);
   assign drain      = !pipe_req && !fifo_empty;
   assign head_addr  = fifo_addr[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (pipe_req) begin
         rf_we    = 1'b1;
         rf_waddr = pipe_addr;
         rf_wdata = pipe_data;
      end else if (!fifo_empty) begin
         rf_we    = 1'b1;
         rf_waddr = head_addr;
         rf_wdata = head_data;
      end
   end

   assign stall = force_stall
                | ((rs_addr1 != 5'd0) && pending[rs_addr1])
                | ((rs_addr2 != 5'd0) && pending[rs_addr2]);

   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_addr[wr_ptr] <= lu_addr;
         fifo_data[wr_ptr] <= lu_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         pending     <= '0;
         starve_cnt  <= '0;
         force_stall <= 1'b0;
         waw_err     <= 1'b0;
      end else begin
         if (enq)
            wr_ptr <= wr_ptr + PW'(1);
         if (drain)
            rd_ptr <= rd_ptr + PW'(1);
         if (enq && !drain)
            count <= count + CW'(1);
         else if (!enq && drain)
            count <= count - CW'(1);

         // A non-empty FIFO that is not draining has lost to the pipeline this cycle.
         if (drain || fifo_empty)
            starve_cnt <= '0;
         else if (starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + SW'(1);
         if (drain)
            force_stall <= 1'b0;
         else if (!fifo_empty && starve_cnt >= SW'(STARVE_LIMIT - 1))
            force_stall <= 1'b1;

         // The set follows the clear so a same-cycle re-issue keeps the register pending.
         if (drain)
            pending[head_addr] <= 1'b0;
         if (issue_valid && issue_addr != 5'd0)
            pending[issue_addr] <= 1'b1;

         if (pipe_req && pending[pipe_addr])
            waw_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vectors, corner sequences and random run against a queue model
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic        clk;
   logic        reset;
   logic        pipe_we;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        lu_valid;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic [4:0]  rs_addr1;
   logic [4:0]  rs_addr2;
   logic        stall;
   logic        force_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        waw_err;

   int total = 0;
   int bad   = 0;

   regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
      .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .rs_addr1(rs_addr1), .rs_addr2(rs_addr2),
      .stall(stall), .force_stall(force_stall),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .waw_err(waw_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        pw;  logic [4:0] pa; logic [31:0] pd;
      logic        lv;  logic [4:0] la; logic [31:0] ld;
      logic        iv;  logic [4:0] ia;
      logic [4:0]  r1;  logic [4:0] r2;
      logic        e_ready; logic e_stall; logic e_fs; logic e_we;
      logic [4:0]  e_wa; logic [31:0] e_wd; logic e_waw;
   } vec_t;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   vec_t vecs[$];

   ent_t      m_q[$];
   bit [31:0] m_pend;
   int        m_starve;
   bit        m_fs;
   bit        m_waw;

   function automatic vec_t mk(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                               input logic lv, input logic [4:0] la, input logic [31:0] ld,
                               input logic iv, input logic [4:0] ia,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic e_ready, input logic e_stall, input logic e_fs,
                               input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
                               input logic e_waw);
      vec_t v;
      v = '{pw, pa, pd, lv, la, ld, iv, ia, r1, r2, e_ready, e_stall, e_fs, e_we, e_wa, e_wd, e_waw};
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input logic e_ready, input logic e_stall,
                            input logic e_fs, input logic e_we, input logic [4:0] e_wa,
                            input logic [31:0] e_wd, input logic e_waw);
      chk({tag, " lu_ready"},    32'(lu_ready),    32'(e_ready));
      chk({tag, " stall"},       32'(stall),       32'(e_stall));
      chk({tag, " force_stall"}, 32'(force_stall), 32'(e_fs));
      chk({tag, " rf_we"},       32'(rf_we),       32'(e_we));
      chk({tag, " rf_waddr"},    32'(rf_waddr),    32'(e_wa));
      chk({tag, " rf_wdata"},    rf_wdata,         e_wd);
      chk({tag, " waw_err"},     32'(waw_err),     32'(e_waw));
   endtask

   task automatic set_in(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ia,
                         input logic [4:0] r1, input logic [4:0] r2);
      pipe_we = pw; pipe_addr = pa; pipe_data = pd;
      lu_valid = lv; lu_addr = la; lu_data = ld;
      issue_valid = iv; issue_addr = ia;
      rs_addr1 = r1; rs_addr2 = r2;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      next_cycle();
      m_q.delete();
      m_pend = '0;
      m_starve = 0;
      m_fs = 0;
      m_waw = 0;
   endtask

   // Outputs the model predicts for the current cycle from its state and the driven inputs.
   task automatic model_expect(output logic e_ready, output logic e_stall, output logic e_fs,
                               output logic e_we, output logic [4:0] e_wa,
                               output logic [31:0] e_wd, output logic e_waw);
      bit preq;
      preq    = pipe_we && pipe_addr != 0;
      e_ready = m_q.size() < DEPTH;
      e_fs    = m_fs;
      e_waw   = m_waw;
      e_stall = m_fs || (rs_addr1 != 0 && m_pend[rs_addr1]) || (rs_addr2 != 0 && m_pend[rs_addr2]);
      if (preq) begin
         e_we = 1; e_wa = pipe_addr; e_wd = pipe_data;
      end else if (m_q.size() > 0) begin
         e_we = 1; e_wa = m_q[0].a; e_wd = m_q[0].d;
      end else begin
         e_we = 0; e_wa = 0; e_wd = 0;
      end
   endtask

   task automatic model_step();
      bit preq;
      int n;
      bit took;
      preq = pipe_we && pipe_addr != 0;
      n    = m_q.size();
      took = lu_valid && n < DEPTH;
      if (preq && m_pend[pipe_addr])
         m_waw = 1;
      if (!preq && n > 0) begin
         m_pend[m_q[0].a] = 0;
         void'(m_q.pop_front());
         m_starve = 0;
         m_fs = 0;
      end else if (n == 0) begin
         m_starve = 0;
      end else begin
         m_starve++;
         if (m_starve >= LIMIT)
            m_fs = 1;
      end
      if (took && lu_addr != 0)
         m_q.push_back('{lu_addr, lu_data});
      if (issue_valid && issue_addr != 0)
         m_pend[issue_addr] = 1;
   endtask

   initial begin
      logic        e_ready, e_stall, e_fs, e_we, e_waw;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      int          hi;

      reset = 1'b1;
      idle();

      //        pw pa  pd          lv la  ld            iv ia r1 r2   rdy stl fs we wa wd            waw
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 1, 5, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0, 0, 0,            0));
      vecs.push_back(mk(1, 0, 32'h55,   0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        1, 0, 32'h77,       0, 0, 0, 0,  1, 0, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            1, 9, 0, 0,  1, 0, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 9, 0,  1, 1, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        1, 9, 32'h99,       0, 0, 9, 0,  1, 1, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 9, 0,  1, 1, 0, 1, 9, 32'h99,       0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 9, 0,  1, 0, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        1, 9, 32'h0A,       0, 0, 0, 0,  1, 0, 0, 0, 0, 0,            0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            1, 9, 9, 0,  1, 0, 0, 1, 9, 32'h0A,       0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 9, 0,  1, 1, 0, 0, 0, 0,            0));
      vecs.push_back(mk(1, 9, 32'h123,  0, 0, 0,            0, 0, 9, 0,  1, 1, 0, 1, 9, 32'h123,      0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0, 0, 0,            1));
      vecs.push_back(mk(1, 4, 32'h5,    0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 1, 4, 32'h5,        1));

      do_reset();
      foreach (vecs[i]) begin
         set_in(vecs[i].pw, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld,
                vecs[i].iv, vecs[i].ia, vecs[i].r1, vecs[i].r2);
         @(negedge clk);
         check_out($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_fs,
                   vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_waw);
         next_cycle();
      end

      // Starvation: one queued entry loses to a pipeline held on r3.
      do_reset();
      set_in(1, 3, 32'h11, 1, 7, 32'h77, 0, 0, 0, 0);
      @(negedge clk);
      check_out("starve enq", 1, 0, 0, 1, 3, 32'h11, 0);
      next_cycle();
      lu_valid = 0;
      for (int i = 1; i <= LIMIT; i++) begin
         @(negedge clk);
         check_out($sformatf("starve lose%0d", i), 1, 0, 0, 1, 3, 32'h11, 0);
         next_cycle();
      end
      @(negedge clk);
      check_out("starve forced", 1, 1, 1, 1, 3, 32'h11, 0);
      next_cycle();
      pipe_we = 0;
      @(negedge clk);
      check_out("starve drain", 1, 1, 1, 1, 7, 32'h77, 0);
      next_cycle();
      @(negedge clk);
      check_out("starve clear", 1, 0, 0, 0, 0, 0, 0);
      next_cycle();

      // Fill to full behind the pipeline, offer extra entries while full, then drain in order.
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
         set_in(1, 3, 32'h11, 1, 5'(10 + k), 32'(100 + k), 0, 0, 0, 0);
         @(negedge clk);
         chk($sformatf("fill%0d lu_ready", k), 32'(lu_ready), 32'd1);
         next_cycle();
      end
      set_in(1, 3, 32'h11, 1, 5'd14, 32'd114, 0, 0, 0, 0);
      @(negedge clk);
      chk("full lu_ready", 32'(lu_ready), 32'd0);
      next_cycle();
      for (int k = 0; k < DEPTH; k++) begin
         if (k == 0) set_in(0, 0, 0, 1, 5'd15, 32'd115, 0, 0, 0, 0);
         else idle();
         @(negedge clk);
         check_out($sformatf("drain%0d", k), (k == 0) ? 1'b0 : 1'b1, 0, 0, 1, 5'(10 + k), 32'(100 + k), 0);
         next_cycle();
      end
      @(negedge clk);
      check_out("drained", 1, 0, 0, 0, 0, 0, 0);
      next_cycle();
      for (int k = 0; k < 6; k++) begin
         set_in(0, 0, 0, 1, 5'(16 + k), 32'(200 + k), 0, 0, 0, 0);
         @(negedge clk);
         if (k == 0) check_out("wrap0", 1, 0, 0, 0, 0, 0, 0);
         else check_out($sformatf("wrap%0d", k), 1, 0, 0, 1, 5'(15 + k), 32'(199 + k), 0);
         next_cycle();
      end
      idle();
      @(negedge clk);
      check_out("wrap last", 1, 0, 0, 1, 5'd21, 32'd205, 0);
      next_cycle();
      @(negedge clk);
      check_out("wrap empty", 1, 0, 0, 0, 0, 0, 0);
      next_cycle();

      // Reset asserted in the middle of draining three entries.
      do_reset();
      set_in(1, 3, 32'h11, 1, 5'd20, 32'd300, 1, 5'd20, 0, 0);
      next_cycle();
      set_in(1, 3, 32'h11, 1, 5'd21, 32'd301, 1, 5'd21, 0, 0);
      next_cycle();
      set_in(1, 3, 32'h11, 1, 5'd22, 32'd302, 0, 0, 0, 0);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 5'd21, 0);
      @(negedge clk);
      check_out("mid drain", 1, 1, 0, 1, 5'd20, 32'd300, 0);
      next_cycle();
      #2;
      reset = 1'b1;
      #1;
      check_out("in reset", 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         @(negedge clk);
         check_out($sformatf("post reset%0d", i), 1, 0, 0, 0, 0, 0, 0);
      end

      // Random traffic against the queue model, alternating heavy and light pipeline phases.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         hi = ((cyc / 50) % 2 == 1) ? 90 : 30;
         set_in($urandom_range(0, 99) < hi, 5'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         @(negedge clk);
         model_expect(e_ready, e_stall, e_fs, e_we, e_wa, e_wd, e_waw);
         check_out($sformatf("rnd%0d", cyc), e_ready, e_stall, e_fs, e_we, e_wa, e_wd, e_waw);
         model_step();
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two sources: the in-order pipeline writeback and a long-latency unit (load / mul-div) result stream.
- Long-latency results are buffered in a small FIFO.
- Keeps a 32-entry pending scoreboard so readers of a not-yet-written destination are stalled.
- Sits between the writeback stage, the long-latency unit and the register file write port (we / writeaddr / writedata).

Parameters:
- DEPTH, 4: long-latency result FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8: consecutive cycles a non-empty FIFO head may lose arbitration before force_stall asserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pipe_we  in  1  pipeline writeback request.
- pipe_addr  in  5  pipeline destination register.
- pipe_data  in  32  pipeline write data.
- lu_valid  in  1  long-latency result valid.
- lu_addr  in  5  long-latency destination register.
- lu_data  in  32  long-latency result data.
- lu_ready  out  1  FIFO can accept this cycle.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_addr  in  5  its destination register.
- rs_addr1  in  5  decode-stage source register 1.
- rs_addr2  in  5  decode-stage source register 2.
- stall  out  1  decode must hold.
- force_stall  out  1  starvation bubble request to the pipeline.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- waw_err  out  1  sticky: pipeline wrote a pending register.

Behaviour:
- Reset (async, immediate):
  - FIFO empty; count 0; rd/wr pointers 0.
  - pending vector all 0; starvation counter 0.
  - force_stall 0; waw_err 0.
  - rf_we / rf_waddr / rf_wdata combinational from state, so they read 0 with inputs idle.
  - lu_ready 1 once reset deasserts.
- Valid requests:
  - Pipeline request valid only when pipe_we=1 and pipe_addr!=0.
  - Address 0 never written, never pending.
- Enqueue:
  - Occurs when lu_valid && lu_ready.
  - lu_addr=0 is accepted but not stored.
  - lu_ready = (count < DEPTH), combinational on registered count. A full FIFO does not accept, even if it drains this cycle.
- Arbitration (combinational, same cycle), fixed priority:
  - 1. pipeline request: rf_we=1, rf_waddr=pipe_addr, rf_wdata=pipe_data.
  - 2. else FIFO non-empty: drain head; rf_we=1, head addr/data; rd pointer advances at clk.
  - 3. else rf_we=0, rf_waddr=0, rf_wdata=0.
- No FIFO bypass:
  - An entry enqueued at edge N is first eligible in cycle N+1.
  - Minimum enqueue-to-regfile latency is 1 cycle; the write commits at the following edge.
- Simultaneous enqueue and drain: count unchanged; pointers wrap modulo DEPTH.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the pipeline wins.
  - Clears on any drain or when the FIFO is empty.
  - force_stall is registered: set when counter reaches STARVE_LIMIT-1 and increments; cleared the cycle after a drain.
  - Upstream guarantees pipe_we=0 within 2 cycles of force_stall.
- Scoreboard:
  - issue_valid && issue_addr!=0 sets pending[issue_addr].
  - A drain clears pending[head addr].
  - Same-cycle set and clear on the same address: set wins.
  - Multiple in-flight ops to one register are not tracked separately; the issuer must not re-issue to a pending register.
- stall = force_stall | pending[rs_addr1] | pending[rs_addr2], with index-0 terms forced 0; combinational.
- waw_err:
  - Set at the edge where the pipeline request targets a pending register.
  - Held until reset.
  - The write still proceeds.
- Reset mid-operation: FIFO contents and pending bits discarded; no write to the register file during or after reset until new requests arrive.

Test Plan:
- Idle, then lu_valid with addr=5, data=0xDEADBEEF at edge 1, pipe idle: cycle 2 shows rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; FIFO empty after edge 2.
- Same-cycle conflict:
  - Stimulus: pipe_we addr=3 data=0x11 every cycle, with one FIFO entry addr=7.
  - Response: pipeline always granted; counter climbs; force_stall=1 after 8 losing cycles.
  - Then drop pipe_we: addr=7 drains next cycle and force_stall clears the following cycle.
- Fill FIFO with 4 entries while pipe_we held: lu_ready=0. A 5th lu_valid is not accepted. Release pipe: entries drain in order, one per cycle, with correct addr/data, and pointer wrap is exercised on a second fill.
- Scoreboard and stall:
  - issue_valid addr=9, then rs_addr1=9: stall=1.
  - rs_addr2=0 alone: stall=0.
  - Result for addr 9 drains: stall=0 the cycle after the drain edge.
  - issue addr=9 in the same cycle as the drain of 9: pending stays 1.
- Degenerate and error cases:
  - pipe_we addr=0: rf_we=0.
  - lu entry addr=0: accepted, never written.
  - pipe_we addr=9 while 9 is pending: write happens, waw_err=1 and stays 1.
- Assert reset mid-drain with 3 entries queued: outputs and pending clear immediately; after release, no rf_we without new requests and lu_ready=1.
